hex_scan_scheduler: RTL and testbench

HEX_SCAN_SCHEDULER -- requirements
Module: hex_scan_scheduler

---
 rtl/hex_scan_scheduler.sv | 176 +++++++++++++++++
 tb/tb_hex_scan_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_scheduler.sv
// hex_scan_scheduler
//   Converts a packed BCD value into seven-segment codes for NUM_DIGITS
//   displays by time-sharing one external combinational BCD-to-7seg decoder.
//   Digits are scanned from most significant to least significant, so
//   leading-zero blanking falls out of a single running flag. Results are
//   collected in a shadow buffer and published to hex in one cycle, so a
//   display never shows a partial update.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   load     in   request to convert value (sampled every edge)
//   value    in   4*NUM_DIGITS BCD digits, digit 0 least significant
//   dec_in   out  registered nibble to the shared decoder
//   dec_out  in   active-low segment code from the shared decoder
//   hex      out  committed segment codes, hex[7i+6:7i] drives display i
//   busy     out  scan in progress
//   done     out  one-cycle pulse when new hex values become visible
//   err      out  last committed value held a nibble greater than 9
module hex_scan_scheduler #(
    parameter int         NUM_DIGITS = 6,
    parameter int         BLANK_LZ   = 1,
    parameter logic [6:0] SEG_OFF    = 7'h7F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int             IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, COMMIT} state_t;

    state_t                  state_q,    state_d;
    logic [4*NUM_DIGITS-1:0] snap_q,     snap_d;
    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic                    blank_q,    blank_d;
    logic                    err_acc_q,  err_acc_d;
    logic [3:0]              dec_in_q,   dec_in_d;
    logic [7*NUM_DIGITS-1:0] shadow_q,   shadow_d;
    logic [7*NUM_DIGITS-1:0] hex_q,      hex_d;
    logic                    err_q,      err_d;
    logic                    done_q,     done_d;
    logic                    pend_q,     pend_d;
    logic [4*NUM_DIGITS-1:0] pend_buf_q, pend_buf_d;

    logic [3:0]              nib;
    logic                    start;
    logic [4*NUM_DIGITS-1:0] start_val;

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        blank_d    = blank_q;
        err_acc_d  = err_acc_q;
        dec_in_d   = dec_in_q;
        shadow_d   = shadow_q;
        hex_d      = hex_q;
        err_d      = err_q;
        done_d     = 1'b0;
        pend_d     = pend_q;
        pend_buf_d = pend_buf_q;
        start      = 1'b0;
        start_val  = value;
        nib        = snap_q[int'(idx_q)*4 +: 4];

        // Any request arriving while a scan is underway (COMMIT included)
        // is parked; a newer request simply overwrites the older one.
        if (state_q != IDLE && load) begin
            pend_d     = 1'b1;
            pend_buf_d = value;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    start     = 1'b1;
                    start_val = value;
                end
            end
            DRIVE: begin
                dec_in_d = nib;
                state_d  = SAMPLE;
            end
            SAMPLE: begin
                // dec_in has been stable for a full cycle here, so dec_out
                // is settled for the current digit.
                if (nib > 4'd9) begin
                    shadow_d[int'(idx_q)*7 +: 7] = SEG_OFF;
                    err_acc_d = 1'b1;
                    blank_d   = 1'b0;
                end else if (blank_q && nib == 4'd0 && idx_q != '0) begin
                    shadow_d[int'(idx_q)*7 +: 7] = SEG_OFF;
                end else begin
                    shadow_d[int'(idx_q)*7 +: 7] = dec_out;
                    blank_d   = 1'b0;
                end
                if (idx_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = DRIVE;
                end
            end
            COMMIT: begin
                hex_d  = shadow_q;
                err_d  = err_acc_q;
                done_d = 1'b1;
                // A load in this very cycle is the newest request and wins
                // over anything parked earlier.
                if (load || pend_q) begin
                    start     = 1'b1;
                    start_val = load ? value : pend_buf_q;
                    pend_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            snap_d    = start_val;
            idx_d     = IDX_TOP;
            blank_d   = (BLANK_LZ != 0);
            err_acc_d = 1'b0;
            state_d   = DRIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            blank_q    <= 1'b0;
            err_acc_q  <= 1'b0;
            dec_in_q   <= 4'd0;
            shadow_q   <= {NUM_DIGITS{SEG_OFF}};
            hex_q      <= {NUM_DIGITS{SEG_OFF}};
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            blank_q    <= blank_d;
            err_acc_q  <= err_acc_d;
            dec_in_q   <= dec_in_d;
            shadow_q   <= shadow_d;
            hex_q      <= hex_d;
            err_q      <= err_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            pend_buf_q <= pend_buf_d;
        end
    end

    assign dec_in = dec_in_q;
    assign hex    = hex_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Testbench for hex_scan_scheduler: two instances (leading-zero blanking on
// and off) share clock, reset and stimulus, each wired to its own copy of
// the BCD-to-7seg decoder. A transaction-level model predicts busy, done,
// hex and err every cycle.
module tb_hex_scan_scheduler;

    localparam int N = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             load;
    logic [4*N-1:0]   value;

    logic [3:0]       dec_in_a,  dec_in_b;
    logic [6:0]       dec_out_a, dec_out_b;
    logic [7*N-1:0]   hex_a,     hex_b;
    logic             busy_a, busy_b, done_a, done_b, err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h06;
        endcase
    endfunction

    assign dec_out_a = seg7(dec_in_a);
    assign dec_out_b = seg7(dec_in_b);

    hex_scan_scheduler #(.NUM_DIGITS(N), .BLANK_LZ(1), .SEG_OFF(7'h7F)) dut_a (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .dec_in(dec_in_a), .dec_out(dec_out_a), .hex(hex_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    hex_scan_scheduler #(.NUM_DIGITS(N), .BLANK_LZ(0), .SEG_OFF(7'h7F)) dut_b (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .dec_in(dec_in_b), .dec_out(dec_out_b), .hex(hex_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Display i shows nothing if it is invalid, or if blanking is on, it is
    // not digit 0 and it and every digit above it are zero.
    function automatic logic [7*N-1:0] hex_model(input logic [4*N-1:0] v, input bit blz);
        logic [7*N-1:0] h;
        logic [3:0]     d;
        bit             all_zero_above;
        h = '0;
        all_zero_above = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d != 4'd0) all_zero_above = 1'b0;
            if (d > 4'd9)                          h[7*i +: 7] = 7'h7F;
            else if (blz && i != 0 && all_zero_above) h[7*i +: 7] = 7'h7F;
            else                                   h[7*i +: 7] = seg7(d);
        end
        return h;
    endfunction

    function automatic bit err_model(input logic [4*N-1:0] v);
        bit e;
        e = 1'b0;
        for (int i = 0; i < N; i++) if (v[4*i +: 4] > 4'd9) e = 1'b1;
        return e;
    endfunction

    // Transaction-level reference: a scan occupies 2N+1 edges after its start.
    bit             m_active = 1'b0;
    int             m_rem    = 0;
    logic [4*N-1:0] m_cur    = '0;
    bit             m_pend   = 1'b0;
    logic [4*N-1:0] m_pend_v = '0;
    logic [7*N-1:0] exp_hex_a = {N{7'h7F}};
    logic [7*N-1:0] exp_hex_b = {N{7'h7F}};
    bit             exp_err  = 1'b0;
    bit             exp_done = 1'b0;

    task automatic model_edge();
        if (rst) begin
            m_active  = 1'b0;
            m_pend    = 1'b0;
            exp_hex_a = {N{7'h7F}};
            exp_hex_b = {N{7'h7F}};
            exp_err   = 1'b0;
            exp_done  = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (m_active) begin
                if (load) begin
                    m_pend   = 1'b1;
                    m_pend_v = value;
                end
                m_rem--;
                if (m_rem == 0) begin
                    exp_hex_a = hex_model(m_cur, 1'b1);
                    exp_hex_b = hex_model(m_cur, 1'b0);
                    exp_err   = err_model(m_cur);
                    exp_done  = 1'b1;
                    if (m_pend) begin
                        m_cur  = m_pend_v;
                        m_pend = 1'b0;
                        m_rem  = 2*N + 1;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (load) begin
                m_active = 1'b1;
                m_cur    = value;
                m_rem    = 2*N + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("busy_a", 64'(busy_a), 64'(m_active));
        check("busy_b", 64'(busy_b), 64'(m_active));
        check("done_a", 64'(done_a), 64'(exp_done));
        check("done_b", 64'(done_b), 64'(exp_done));
        check("hex_a",  64'(hex_a),  64'(exp_hex_a));
        check("hex_b",  64'(hex_b),  64'(exp_hex_b));
        check("err_a",  64'(err_a),  64'(exp_err));
        check("err_b",  64'(err_b),  64'(exp_err));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        load  = 1'b1;
        value = v;
        tick();
        load  = 1'b0;
        value = 24'($urandom);
    endtask

    // Returns the number of edges until done_a is seen, or 21 on timeout.
    task automatic wait_done(output int k);
        k = 21;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done_a) begin
                k = i;
                break;
            end
        end
    endtask

    function automatic logic [4*N-1:0] rand_bcd();
        logic [4*N-1:0] v;
        int sig;
        v = '0;
        sig = $urandom_range(0, N);
        for (int i = 0; i < N; i++) begin
            if (i < sig) begin
                if ($urandom_range(0, 9) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
            end
        end
        return v;
    endfunction

    logic [7*N-1:0] want;
    int             lat;

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        run(3);
        rst = 1'b0;
        check("rst_dec_in_a", 64'(dec_in_a), 64'd0);
        check("rst_dec_in_b", 64'(dec_in_b), 64'd0);
        run(2);

        // 000123: upper three blanked
        do_load(24'h000123);
        wait_done(lat);
        check("lat_123", 64'(lat), 64'd13);
        want = {7'h7F, 7'h7F, 7'h7F, seg7(4'd1), seg7(4'd2), seg7(4'd3)};
        check("hex_123", 64'(hex_a), 64'(want));
        check("err_123", 64'(err_a), 64'd0);
        run(2);

        // all zeros: digit 0 still shows
        do_load(24'h000000);
        wait_done(lat);
        want = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, seg7(4'd0)};
        check("hex_zero_blz", 64'(hex_a), 64'(want));
        want = {N{seg7(4'd0)}};
        check("hex_zero_noblz", 64'(hex_b), 64'(want));
        run(1);

        // invalid nibble
        do_load(24'h0000A5);
        wait_done(lat);
        want = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, seg7(4'd5)};
        check("hex_a5", 64'(hex_a), 64'(want));
        check("err_a5", 64'(err_a), 64'd1);
        want = {seg7(4'd0), seg7(4'd0), seg7(4'd0), seg7(4'd0), 7'h7F, seg7(4'd5)};
        check("hex_a5_noblz", 64'(hex_b), 64'(want));
        run(1);

        // back-to-back: the newest pending request wins
        do_load(24'h111111);
        run(2);
        do_load(24'h222222);
        run(3);
        do_load(24'h333333);
        wait_done(lat);
        check("lat_first", 64'(lat), 64'd6);
        check("busy_across_commit", 64'(busy_a), 64'd1);
        want = {N{seg7(4'd1)}};
        check("hex_ones", 64'(hex_a), 64'(want));
        wait_done(lat);
        check("lat_second", 64'(lat), 64'd13);
        want = {N{seg7(4'd3)}};
        check("hex_threes", 64'(hex_a), 64'(want));
        run(3);

        // reset mid-scan
        do_load(24'h654321);
        run(4);
        rst  = 1'b1;
        load = 1'b1;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        check("midrst_dec_in", 64'(dec_in_a), 64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_hex", 64'(hex_a), 64'({N{7'h7F}}));
        run(15);
        do_load(24'h000789);
        wait_done(lat);
        check("lat_after_rst", 64'(lat), 64'd13);
        want = {7'h7F, 7'h7F, 7'h7F, seg7(4'd7), seg7(4'd8), seg7(4'd9)};
        check("hex_after_rst", 64'(hex_a), 64'(want));

        // randomized traffic
        for (int it = 0; it < 500; it++) begin
            rst   = ($urandom_range(0, 149) == 0);
            load  = ($urandom_range(0, 5) == 0);
            value = rand_bcd();
            tick();
        end
        rst  = 1'b0;
        load = 1'b0;
        run(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
